// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks every entry through a dedicated combinational read port and
// streams (address, data) beats over valid/ready. Define DUMP_SKIP_ZERO_EN to skip hardwired reg 0.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic              dump_valid_out,
    input  logic              dump_ready_in,
    output logic [ADDR_W-1:0] dump_addr_out,
    output logic [DATA_W-1:0] dump_data_out,
    output logic              busy_out,
    output logic              done_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`ifdef DUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_dump_addr;
    logic [DATA_W-1:0]   r_dump_data;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_valid_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_dump_addr <= w_addr_nxt;
            r_dump_data <= w_data_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no branch leaves a variable unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_dump_addr;
        w_data_nxt  = r_dump_data;

        case (r_state)
            S_IDLE: begin
                // Abort beats a simultaneous start.
                if (start_in && !abort_in) begin
                    w_cnt_nxt   = FIRST_ADDR;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (abort_in) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_data_nxt  = rd_data_in;
                    w_addr_nxt  = r_cnt;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (abort_in) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (dump_ready_in) begin
                    w_valid_nxt = 1'b0;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + ADDR_W'(1);
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_addr_out    = r_cnt;
    assign dump_valid_out = r_valid;
    assign dump_addr_out  = r_dump_addr;
    assign dump_data_out  = r_dump_data;
    assign busy_out       = (r_state != S_IDLE);
    assign done_out       = (r_state == S_DONE);

endmodule
